// File: rtl/modexp_seq.sv
// Sequential modular exponentiator: base^exponent mod modulus via bit-serial interleaved multipliers.
// Optional MODEXP_CONST_TIME_EN: always run WIDTH square/multiply iterations regardless of exponent.
module modexp_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic             ready,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, REDUCE, STEP, MUL, DONE} state_t;
    state_t state;

    logic [WIDTH-1:0] mod_r, exp_r, acc, bsq;
    logic [WIDTH-1:0] p0, p1, a0_sh, a1_sh;
    logic [WIDTH-1:0] b0, nxt0, nxt1;
    logic [CW-1:0]    cnt;
    logic             bad;
    logic             step_go;

    // One interleaved step: P = 2P mod n, then P = P + abit*b mod n; P,b < n keeps WIDTH+1 bits sufficient.
    function automatic logic [WIDTH-1:0] mm_step(input logic [WIDTH-1:0] p, input logic abit,
                                                 input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] n);
        logic [WIDTH:0] d, s;
        d = {p, 1'b0};
        if (d >= {1'b0, n}) d = d - {1'b0, n};
        s = d + (abit ? {1'b0, b} : '0);
        if (s >= {1'b0, n}) s = s - {1'b0, n};
        return s[WIDTH-1:0];
    endfunction

`ifdef MODEXP_CONST_TIME_EN
    localparam int IW = $clog2(WIDTH + 1);
    logic [IW-1:0] iter;
    assign step_go = (iter != IW'(WIDTH));
`else
    assign step_go = |exp_r;
`endif

    // Multiplier 0 reduces base (b=1) during REDUCE and forms acc*bsq during MUL.
    always_comb begin
        b0   = (state == REDUCE) ? WIDTH'(1) : bsq;
        nxt0 = mm_step(p0, a0_sh[WIDTH-1], b0, mod_r);
        nxt1 = mm_step(p1, a1_sh[WIDTH-1], bsq, mod_r);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            ready  <= 1'b1;
            done   <= 1'b0;
            err    <= 1'b0;
            result <= '0;
            mod_r  <= '0;
            exp_r  <= '0;
            acc    <= '0;
            bsq    <= '0;
            p0     <= '0;
            p1     <= '0;
            a0_sh  <= '0;
            a1_sh  <= '0;
            cnt    <= '0;
            bad    <= 1'b0;
`ifdef MODEXP_CONST_TIME_EN
            iter   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    mod_r <= modulus;
                    exp_r <= exponent;
                    a0_sh <= base;
                    acc   <= WIDTH'(1);
                    p0    <= '0;
                    cnt   <= '0;
                    err   <= 1'b0;
                    ready <= 1'b0;
                    bad   <= (modulus < WIDTH'(2));
`ifdef MODEXP_CONST_TIME_EN
                    iter  <= '0;
`endif
                    state <= (modulus < WIDTH'(2)) ? DONE : REDUCE;
                end
                REDUCE: begin
                    p0    <= nxt0;
                    a0_sh <= a0_sh << 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        bsq   <= nxt0;
                        state <= STEP;
                    end
                end
                STEP: begin
                    if (!step_go) begin
                        state <= DONE;
                    end else begin
                        a0_sh <= acc;
                        a1_sh <= bsq;
                        p0    <= '0;
                        p1    <= '0;
                        cnt   <= '0;
                        state <= MUL;
`ifdef MODEXP_CONST_TIME_EN
                        iter  <= iter + IW'(1);
`endif
                    end
                end
                MUL: begin
                    p0    <= nxt0;
                    p1    <= nxt1;
                    a0_sh <= a0_sh << 1;
                    a1_sh <= a1_sh << 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        if (exp_r[0]) acc <= nxt0;
                        bsq   <= nxt1;
                        exp_r <= exp_r >> 1;
                        state <= STEP;
                    end
                end
                DONE: begin
                    done   <= 1'b1;
                    err    <= bad;
                    result <= bad ? '0 : acc;
                    ready  <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_modexp_seq.sv
// Scoreboard bench for modexp_seq (WIDTH=16); expected results and done latencies are queued at issue.
module tb_modexp_seq;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] base = '0, exponent = '0, modulus = '0;
    logic         ready, done, err;
    logic [W-1:0] result;

    typedef struct {
        logic [W-1:0] res;
        logic         er;
        int           t;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    modexp_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .base(base), .exponent(exponent),
        .modulus(modulus), .ready(ready), .done(done), .err(err), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic int exp_lat(input logic [W-1:0] e);
`ifdef MODEXP_CONST_TIME_EN
        return W + W * (W + 1) + 2;
`else
        int k = 0;
        for (int i = 0; i < W; i++) if (e[i]) k = i + 1;
        return W + k * (W + 1) + 2;
`endif
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && done) begin : mon
            exp_t x;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done result %0d expected no done", result);
            end else begin
                x = sb.pop_front();
                chk("result", result, x.res);
                chk("err", err, x.er);
                chk("latency", cyc - x.t, x.lat);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout ready %0d expected 1", ready);
        end
    endtask

    task automatic issue(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m,
                         input bit push, input logic [W-1:0] r, input logic er);
        @(negedge clk);
        wait_ready();
        base = b;
        exponent = e;
        modulus = m;
        start = 1'b1;
        if (push) sb.push_back('{r, er, cyc + 1, er ? 1 : exp_lat(e)});
        @(negedge clk);
        start = 1'b0;
        chk("ready_low_after_start", ready, 0);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout pending %0d expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic op(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m,
                      input logic [W-1:0] r, input logic er);
        issue(b, e, m, 1'b1, r, er);
        drain();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_result", result, 0);

        op(16'd4, 16'd13, 16'd497, 16'd445, 1'b0);
        op(16'd65, 16'd17, 16'd3233, 16'd2790, 1'b0);
        op(16'd2790, 16'd2753, 16'd3233, 16'd65, 1'b0);
        op(16'd10, 16'd3, 16'd7, 16'd6, 1'b0);
        op(16'd3, 16'd0, 16'd7, 16'd1, 1'b0);
        op(16'd0, 16'd5, 16'd7, 16'd0, 1'b0);
        op(16'd2, 16'd16, 16'd65535, 16'd1, 1'b0);
        op(16'd65535, 16'd1, 16'd65535, 16'd0, 1'b0);
        op(16'd65534, 16'd2, 16'd65535, 16'd1, 1'b0);
        op(16'd9, 16'd4, 16'd1, 16'd0, 1'b1);
        op(16'd9, 16'd4, 16'd0, 16'd0, 1'b1);
        op(16'd3, 16'd2, 16'd7, 16'd2, 1'b0);

        // start held through the DONE cycle: ignored there, accepted one cycle later
        @(negedge clk);
        wait_ready();
        base = 16'd5;
        exponent = 16'd3;
        modulus = 16'd0;
        start = 1'b1;
        sb.push_back('{16'd0, 1'b1, cyc + 1, 1});
        @(negedge clk);
        base = 16'd3;
        exponent = 16'd0;
        modulus = 16'd7;
        sb.push_back('{16'd1, 1'b0, cyc + 2, exp_lat(16'd0)});
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        drain();

        // start mid-operation with other operands must be ignored
        issue(16'd4, 16'd13, 16'd497, 1'b1, 16'd445, 1'b0);
        repeat (10) @(negedge clk);
        base = 16'd9;
        exponent = 16'd9;
        modulus = 16'd11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        // reset mid-MUL discards the operation
        issue(16'd65, 16'd17, 16'd3233, 1'b0, 16'd0, 1'b0);
        repeat (40) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_ready", ready, 1);
        chk("midrst_done", done, 0);
        chk("midrst_result", result, 0);
        chk("midrst_err", err, 0);
        repeat (150) @(negedge clk);
        op(16'd4, 16'd13, 16'd497, 16'd445, 1'b0);

        // fixed-latency candidates under constant-time build; 2^65535 mod 65521 = 2^15
        op(16'd2, 16'd0, 16'd65521, 16'd1, 1'b0);
        op(16'd2, 16'd65535, 16'd65521, 16'd32768, 1'b0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/modexp_seq.md
Name: modexp_seq

Overview:
- Iterative, area-lean successor to the combinational-divider exponentiator: computes base^exponent mod modulus with a bit-serial interleaved modular multiplier, one product bit per clock.
- Sits between the key generator and message path of the RSA control block.
- Replaces free-running reset-to-load operation with a start/ready/done handshake, an error flag and parametrised operand width.

Parameters:
WIDTH, 32, operand width in bits of base, exponent, modulus and result.

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; accepted only when ready=1
base  input  WIDTH  message/base operand, sampled on accepted start
exponent  input  WIDTH  exponent e or d, sampled on accepted start
modulus  input  WIDTH  modulus n, sampled on accepted start
ready  output  1  1 in IDLE only
done  output  1  single-cycle pulse: result and err valid
err  output  1  modulus<2 on last operation; held until next accepted start
result  output  WIDTH  last result; held until next accepted start

Behaviour:
- Reset (takes priority over everything, including mid-operation): state=IDLE, ready=1, done=0, err=0, result=0, all internal registers cleared. An in-flight operation is discarded, with no done pulse.
- States: IDLE, REDUCE, STEP, MUL, DONE.
- IDLE:
  - start=1 at edge t latches base, exponent and modulus, clears err, and sets acc=1.
  - If modulus<2: go to DONE with err=1 and result=0. The done pulse occurs at t+1.
  - Otherwise go to REDUCE. start while not IDLE is ignored, with no queueing.
- Modular multiplier MM(a,b), with b<n, over WIDTH cycles, MSB first:
  - P=0.
  - Each cycle: P=2P, minus n if >=n; then if a[i], P=P+b, minus n if >=n.
  - Internal adder width is WIDTH+1, so no overflow is possible.
- REDUCE: WIDTH cycles computing bsq=MM(base,1)=base mod n. Then go to STEP.
- STEP (1 cycle):
  - If exp_reg==0, go to DONE.
  - Otherwise go to MUL and launch two multipliers in parallel: MM(acc,bsq) and MM(bsq,bsq).
- MUL: WIDTH cycles. On the last cycle:
  - If exp_reg[0], then acc<=acc*bsq mod n.
  - bsq<=bsq^2 mod n.
  - exp_reg<=exp_reg>>1.
  - Go to STEP.
- DONE (1 cycle): done=1, result<=acc (0 if err), go to IDLE. ready=0 during DONE.
- Latency:
  - For an accepted start at edge t with modulus>=2 and k = bit-length of exponent (k=0 for exponent=0), done is high in cycle t+WIDTH+k*(WIDTH+1)+2.
  - Worst case is t+WIDTH+WIDTH*(WIDTH+1)+2.
- Boundaries:
  - exponent=0 gives result 1.
  - base>=modulus is handled by REDUCE.
  - base=0 with exponent>0 gives 0.
  - modulus=2^WIDTH-1 must give correct results.
  - start asserted in the DONE cycle is ignored; it is accepted the following cycle, when ready=1.

Optional Feature:
- Macro MODEXP_CONST_TIME_EN.
- Defined:
  - STEP ignores exp_reg==0 and always performs exactly WIDTH iterations, tracked by an internal counter.
  - Latency is fixed at t+WIDTH+WIDTH*(WIDTH+1)+2, independent of exponent value (timing side-channel hardening).
  - Result values are identical to the undefined build.
  - err path latency is unchanged (t+1).
- Undefined: early exit when exp_reg==0, as specified above.

Test Plan:
- WIDTH=16. reset held 2 cycles, then released: ready=1, done=0, err=0, result=0 → start base=4, exponent=13, modulus=497: done at t+86, result=445, err=0.
- WIDTH=16, RSA round trip:
  - base=65, exponent=17, modulus=3233 → result=2790 at t+103.
  - Then base=2790, exponent=2753, modulus=3233 → result=65 at t+222.
- WIDTH=16, edge operands:
  - base=10, exponent=3, modulus=7 → 6 (base>=n path).
  - base=3, exponent=0, modulus=7 → 1 at t+18.
  - base=0, exponent=5, modulus=7 → 0.
- WIDTH=16, modulus=1 and modulus=0 → done at t+1, err=1, result=0. A following valid start clears err.
- WIDTH=16, control/reset:
  - start pulsed mid-operation with different operands → ignored, original result delivered.
  - reset asserted mid-MUL → ready=1, result=0, no done pulse. A new start then completes correctly.
- MODEXP_CONST_TIME_EN defined, WIDTH=16: exponent=0 and exponent=65535 (base=2, modulus=65521) both give done at t+290, with results 1 and 2^65535 mod 65521 matching the software model.
